// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter and its requester-side client bank.
package rr_arb_pkg;

  // Per-channel client state; SERVE means the channel was granted in the last registered cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SERVE = 2'd2
  } client_state_e;

  // Number of requesters the arbiter and the client bank are built for.
  localparam int RR_NUM_REQ = 4;

  // One service slice: 3 seconds of a 50 MHz clock.
  localparam int RR_CLK_HZ       = 50_000_000;
  localparam int RR_SLICE_SEC    = 3;
  localparam int RR_SLICE_CYCLES = RR_CLK_HZ * RR_SLICE_SEC;

endpackage

// File: rtl/request_client_channel.sv
// One client channel: pending-job counter, accumulated service credit, state and overflow flag.
module request_client_channel
  import rr_arb_pkg::*;
#(
  parameter int CNT_W            = 3,
  parameter int MIN_GRANT_CYCLES = RR_SLICE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_in,
  input  logic             grant_in,
  output logic             request_out,
  output logic             job_done,
  output logic [CNT_W-1:0] pending_count,
  output logic             overflow
);

  localparam int                SVC_W    = $clog2(MIN_GRANT_CYCLES);
  localparam logic [SVC_W-1:0]  SVC_LAST = SVC_W'(MIN_GRANT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  client_state_e    state_r;
  client_state_e    state_next_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic [SVC_W-1:0] svc_r;
  logic [SVC_W-1:0] svc_next_s;
  logic             serve_s;
  logic             complete_s;
  logic             overflow_next_s;
  logic             job_done_r;
  logic             overflow_r;

  // Request is a pure decode of the registered state, so grant_in never reaches it combinationally.
  assign request_out   = (state_r != ST_IDLE);
  assign job_done      = job_done_r;
  assign pending_count = count_r;
  assign overflow      = overflow_r;

  // Next-state logic: service credit, job retirement, arrivals with saturation, and state decode.
  always_comb begin
    serve_s         = 1'b0;
    complete_s      = 1'b0;
    svc_next_s      = svc_r;
    count_next_s    = count_r;
    overflow_next_s = overflow_r;
    state_next_s    = state_r;

    // Grants to a non-requesting channel earn no credit.
    serve_s    = request_out && grant_in;
    complete_s = serve_s && (svc_r == SVC_LAST);

    // Credit is kept across grant gaps and only wraps through completion.
    if (complete_s) begin
      svc_next_s = '0;
    end else if (serve_s) begin
      svc_next_s = svc_r + SVC_W'(1);
    end else begin
      svc_next_s = svc_r;
    end

    case ({job_in, complete_s})
      2'b10: begin
        if (count_r == CNT_MAX) begin
          overflow_next_s = 1'b1;
          count_next_s    = count_r;
        end else begin
          count_next_s    = count_r + CNT_W'(1);
        end
      end
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase

    if (count_next_s == '0) begin
      state_next_s = ST_IDLE;
    end else if (grant_in) begin
      state_next_s = ST_SERVE;
    end else begin
      state_next_s = ST_REQ;
    end
  end

  // Channel state register with synchronous reset discarding jobs and credit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      count_r    <= '0;
      svc_r      <= '0;
      job_done_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      count_r    <= count_next_s;
      svc_r      <= svc_next_s;
      job_done_r <= complete_s;
      overflow_r <= overflow_next_s;
    end
  end

endmodule

// File: rtl/request_client_bank.sv
// Bank of client channels feeding the round-robin arbiter, with a grant-protocol checker.
module request_client_bank
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ          = RR_NUM_REQ,
  parameter int CNT_W            = 3,
  parameter int MIN_GRANT_CYCLES = RR_SLICE_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       job_in,
  input  logic [NUM_REQ-1:0]       grant_in,
  output logic [NUM_REQ-1:0]       request_out,
  output logic [NUM_REQ-1:0]       job_done,
  output logic [NUM_REQ*CNT_W-1:0] pending_count,
  output logic [NUM_REQ-1:0]       overflow,
  output logic                     grant_error
);

  logic stray_grant_s;
  logic multi_grant_s;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_chan
    request_client_channel #(
      .CNT_W            (CNT_W),
      .MIN_GRANT_CYCLES (MIN_GRANT_CYCLES)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .job_in        (job_in[g]),
      .grant_in      (grant_in[g]),
      .request_out   (request_out[g]),
      .job_done      (job_done[g]),
      .pending_count (pending_count[g*CNT_W +: CNT_W]),
      .overflow      (overflow[g])
    );
  end

  // Detect a grant to an idle channel or more than one grant at once.
  always_comb begin
    stray_grant_s = 1'b0;
    multi_grant_s = 1'b0;
    stray_grant_s = ((grant_in & ~request_out) != '0);
    multi_grant_s = ((grant_in & (grant_in - NUM_REQ'(1))) != '0);
  end

  // Sticky protocol-violation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_error <= 1'b0;
    end else begin
      grant_error <= grant_error | stray_grant_s | multi_grant_s;
    end
  end

endmodule

// File: tb/tb_request_client_bank.sv
// Scoreboard bench for request_client_bank with a short service slice.
module tb_request_client_bank;

  localparam int N   = 4;
  localparam int CW  = 3;
  localparam int MGC = 4;
  localparam int CMAX = 7;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   job_in;
  logic [N-1:0]   grant_in;
  logic [N-1:0]   request_out;
  logic [N-1:0]   job_done;
  logic [N*CW-1:0] pending_count;
  logic [N-1:0]   overflow;
  logic           grant_error;

  typedef struct packed {
    logic [N-1:0]    req;
    logic [N-1:0]    done;
    logic [N*CW-1:0] pend;
    logic [N-1:0]    ovf;
    logic            gerr;
  } exp_t;

  exp_t   sb_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     done_seen[N];
  int     m_count[N];
  int     m_svc[N];
  logic [N-1:0] m_ovf;
  logic   m_gerr;

  request_client_bank #(
    .NUM_REQ          (N),
    .CNT_W            (CW),
    .MIN_GRANT_CYCLES (MGC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .job_in        (job_in),
    .grant_in      (grant_in),
    .request_out   (request_out),
    .job_done      (job_done),
    .pending_count (pending_count),
    .overflow      (overflow),
    .grant_error   (grant_error)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge; pushes the expected post-edge outputs.
  task automatic model_step(input logic rst, input logic [N-1:0] j, input logic [N-1:0] g);
    exp_t e;
    logic [N-1:0] req_pre;
    logic serve;
    logic comp;
    e = '0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_count[i] = 0;
        m_svc[i]   = 0;
      end
      m_ovf  = '0;
      m_gerr = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) req_pre[i] = (m_count[i] != 0);
      if (((g & ~req_pre) != '0) || ($countones(g) > 1)) m_gerr = 1'b1;
      for (int i = 0; i < N; i++) begin
        serve = req_pre[i] && g[i];
        comp  = serve && (m_svc[i] == MGC - 1);
        if (comp) m_svc[i] = 0;
        else if (serve) m_svc[i] = m_svc[i] + 1;
        if (j[i] && !comp) begin
          if (m_count[i] == CMAX) m_ovf[i] = 1'b1;
          else m_count[i] = m_count[i] + 1;
        end else if (!j[i] && comp) begin
          m_count[i] = m_count[i] - 1;
        end
        e.done[i] = comp;
      end
    end
    for (int i = 0; i < N; i++) begin
      e.req[i] = (m_count[i] != 0);
      e.pend[i*CW +: CW] = 3'(m_count[i]);
    end
    e.ovf  = m_ovf;
    e.gerr = m_gerr;
    sb_q.push_back(e);
  endtask

  // Drive one cycle, then compare DUT outputs against the scoreboard on the falling edge.
  task automatic step(input logic rst, input logic [N-1:0] j, input logic [N-1:0] g);
    exp_t e;
    reset    = rst;
    job_in   = j;
    grant_in = g;
    model_step(rst, j, g);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check_value("request_out",   32'(request_out),   32'(e.req));
    check_value("job_done",      32'(job_done),      32'(e.done));
    check_value("pending_count", 32'(pending_count), 32'(e.pend));
    check_value("overflow",      32'(overflow),      32'(e.ovf));
    check_value("grant_error",   32'(grant_error),   32'(e.gerr));
    for (int i = 0; i < N; i++) if (job_done[i]) done_seen[i]++;
  endtask

  task automatic clear_seen();
    for (int i = 0; i < N; i++) done_seen[i] = 0;
  endtask

  function automatic logic [CW-1:0] pend_of(input int ch);
    return pending_count[ch*CW +: CW];
  endfunction

  initial begin
    reset    = 1'b1;
    job_in   = '0;
    grant_in = '0;
    m_ovf    = '0;
    m_gerr   = 1'b0;
    clear_seen();

    // Reset state
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b1, 4'b0000, 4'b0000);
    check_value("rst_outputs", 32'({request_out, job_done, overflow, grant_error}), 32'd0);
    check_value("rst_pending", 32'(pending_count), 32'd0);

    // Single job on channel 0
    step(1'b0, 4'b0001, 4'b0000);
    check_value("single_req_up", 32'(request_out[0]), 32'd1);
    check_value("single_cnt1", 32'(pend_of(0)), 32'd1);
    step(1'b0, 4'b0000, 4'b0000);
    for (int k = 0; k < MGC; k++) step(1'b0, 4'b0000, 4'b0001);
    check_value("single_done", 32'(job_done[0]), 32'd1);
    check_value("single_req_low", 32'(request_out[0]), 32'd0);
    check_value("single_cnt0", 32'(pend_of(0)), 32'd0);
    step(1'b0, 4'b0000, 4'b0000);
    check_value("single_done_once", 32'(done_seen[0]), 32'd1);

    // Split credit on channel 2: 2 granted cycles on, 5 off
    clear_seen();
    for (int k = 0; k < 3; k++) step(1'b0, 4'b0100, 4'b0000);
    check_value("split_cnt3", 32'(pend_of(2)), 32'd3);
    for (int r = 0; r < 6; r++) begin
      step(1'b0, 4'b0000, 4'b0100);
      step(1'b0, 4'b0000, 4'b0100);
      for (int k = 0; k < 5; k++) step(1'b0, 4'b0000, 4'b0000);
    end
    check_value("split_pulses", 32'(done_seen[2]), 32'd3);
    check_value("split_req_low", 32'(request_out[2]), 32'd0);

    // Overflow on channel 1
    clear_seen();
    for (int k = 0; k < 8; k++) step(1'b0, 4'b0010, 4'b0000);
    check_value("ovf_cnt_sat", 32'(pend_of(1)), 32'd7);
    check_value("ovf_flag", 32'(overflow[1]), 32'd1);
    for (int k = 0; k < 7 * MGC; k++) step(1'b0, 4'b0000, 4'b0010);
    check_value("ovf_pulses", 32'(done_seen[1]), 32'd7);
    check_value("ovf_sticky", 32'(overflow[1]), 32'd1);
    check_value("ovf_no_gerr", 32'(grant_error), 32'd0);

    // Arrival in the completion cycle on channel 3
    clear_seen();
    step(1'b0, 4'b1000, 4'b0000);
    step(1'b0, 4'b1000, 4'b0000);
    for (int k = 0; k < MGC - 1; k++) step(1'b0, 4'b0000, 4'b1000);
    step(1'b0, 4'b1000, 4'b1000);
    check_value("simul_done", 32'(job_done[3]), 32'd1);
    check_value("simul_cnt", 32'(pend_of(3)), 32'd2);
    for (int k = 0; k < 2 * MGC; k++) step(1'b0, 4'b0000, 4'b1000);
    check_value("simul_drain", 32'(pend_of(3)), 32'd0);

    // Protocol: grant to idle channel
    step(1'b0, 4'b0000, 4'b0100);
    check_value("proto_idle_gerr", 32'(grant_error), 32'd1);
    check_value("proto_idle_cnt", 32'(pend_of(2)), 32'd0);

    // Protocol: two grants with both requesting
    step(1'b1, 4'b0000, 4'b0000);
    check_value("proto_rst_gerr", 32'(grant_error), 32'd0);
    step(1'b0, 4'b0011, 4'b0000);
    step(1'b0, 4'b0000, 4'b0011);
    check_value("proto_multi_gerr", 32'(grant_error), 32'd1);
    for (int k = 0; k < MGC; k++) step(1'b0, 4'b0000, 4'b0001);
    for (int k = 0; k < MGC; k++) step(1'b0, 4'b0000, 4'b0010);

    // Reset mid-serve on channel 0
    step(1'b1, 4'b0000, 4'b0000);
    clear_seen();
    for (int k = 0; k < 3; k++) step(1'b0, 4'b0001, 4'b0000);
    step(1'b0, 4'b0000, 4'b0001);
    step(1'b0, 4'b0000, 4'b0001);
    step(1'b1, 4'b0000, 4'b0000);
    check_value("midrst_outputs", 32'({request_out, job_done, overflow, grant_error}), 32'd0);
    check_value("midrst_pending", 32'(pending_count), 32'd0);
    step(1'b0, 4'b0001, 4'b0000);
    for (int k = 0; k < MGC - 1; k++) step(1'b0, 4'b0000, 4'b0001);
    check_value("midrst_no_early", 32'(done_seen[0]), 32'd0);
    step(1'b0, 4'b0000, 4'b0001);
    check_value("midrst_done", 32'(job_done[0]), 32'd1);
    step(1'b0, 4'b0000, 4'b0000);

    check_value("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
